// File: rtl/prog_loader.sv
// Framed byte-stream program loader: SYNC, LEN, data[, CHK] into program memory, CPU held in reset until done.
// Optional checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst_n,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_REL
  } state_e;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e LAST_ST    = S_CHK;
  localparam logic   READY_LAST = 1'b1;
`else
  localparam state_e LAST_ST    = S_REL;
  localparam logic   READY_LAST = 1'b0;
`endif

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic [7:0]          ptr_q;
  logic [TW-1:0]       tmo_q;
  logic [TW-1:0]       tmo_d;
  logic                rx_ready_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wdata_q;
  logic                we_q;
  logic                cpu_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          sum_q;
  logic [7:0]          sum_d;
`endif

  logic acc;
  logic in_frame;
  logic tmo_fire;

  assign acc      = rx_valid & rx_ready_q;
  assign in_frame = (state_q == S_LEN) |
                    (state_q == S_DATA) |
                    (state_q == S_CHK);
  assign tmo_d    = acc ? '0 : tmo_q + 1'b1;
  assign tmo_fire = in_frame & ~acc & (tmo_q == TMO_LAST);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign sum_d    = sum_q + rx_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      ptr_q      <= 8'd0;
      tmo_q      <= '0;
      rx_ready_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      we_q       <= 1'b0;
      cpu_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      tmo_q  <= in_frame ? tmo_d : '0;
      if (tmo_fire) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (acc && rx_data == SYNC_BYTE) begin
              state_q <= S_LEN;
              err_q   <= 1'b0;
              cpu_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          S_LEN: begin
            if (acc) begin
              cnt_q <= rx_data;
              ptr_q <= 8'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
              sum_q <= rx_data;
`endif
              if (rx_data == 8'd0) begin
                state_q    <= LAST_ST;
                rx_ready_q <= READY_LAST;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (acc) begin
              we_q    <= 1'b1;
              addr_q  <= ADDR_W'(ptr_q);
              wdata_q <= rx_data;
              ptr_q   <= ptr_q + 8'd1;
              cnt_q   <= cnt_q - 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
              sum_q   <= sum_d;
`endif
              if (cnt_q == 8'd1) begin
                state_q    <= LAST_ST;
                rx_ready_q <= READY_LAST;
              end
            end
          end
          S_CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            if (acc) begin
              if (rx_data == sum_q) begin
                state_q    <= S_REL;
                rx_ready_q <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
`else
            state_q <= S_IDLE;
`endif
          end
          S_REL: begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b1;
            cpu_q      <= 1'b1;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_ready  = rx_ready_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign cpu_rst_n = cpu_q;
  assign load_busy = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames plus random frames checked
// against frame-level expectations and a program memory image.
module tb_prog_loader;

  localparam int         T    = 30;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       cpu_rst_n;
  logic       load_busy;
  logic       load_done;
  logic       load_err;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  logic [7:0] exp_mem [256];
  logic [7:0] dut_mem [256];

  prog_loader #(
    .ADDR_W(8),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .cpu_rst_n(cpu_rst_n),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (mem_we === 1'b1) begin
      wr_cnt++;
      dut_mem[mem_addr] = mem_wdata;
    end
    if (load_done === 1'b1) done_cnt++;
    assert (!(load_done === 1'b1 && load_err === 1'b1)) else begin
      miscompares++;
      $error("FAIL done_err_excl: observed done=%0b err=%0b expected not both",
             load_done, load_err);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1);
    check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_load_busy"}, load_busy, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_load_err"}, load_err, 0);
  endtask

  // Starts and ends on a negedge; returns on the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_before_accept", rx_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] junk[$],
                            input logic [7:0] data[$],
                            input int gmax);
    int w0;
    int d0;
    logic [7:0] s;
    foreach (junk[i]) send_byte(junk[i], $urandom_range(gmax, 0));
    check("idle_after_junk_busy", load_busy, 0);
    w0 = wr_cnt;
    d0 = done_cnt;
    send_byte(SYNC, $urandom_range(gmax, 0));
    check("sync_busy", load_busy, 1);
    check("sync_cpu_rst", cpu_rst_n, 0);
    check("sync_err_clr", load_err, 0);
    s = 8'(data.size());
    send_byte(s, $urandom_range(gmax, 0));
    foreach (data[i]) begin
      send_byte(data[i], $urandom_range(gmax, 0));
      s = s + data[i];
      exp_mem[i] = data[i];
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, i);
      check("wr_data", mem_wdata, data[i]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(s, $urandom_range(gmax, 0));
`endif
    check("rel_ready_low", rx_ready, 0);
    check("rel_cpu_held", cpu_rst_n, 0);
    check("rel_no_done", load_done, 0);
    @(negedge clk);
    check("done_cpu_run", cpu_rst_n, 1);
    check("done_pulse", load_done, 1);
    check("done_busy", load_busy, 0);
    check("done_err", load_err, 0);
    check("done_ready", rx_ready, 1);
    @(negedge clk);
    check("done_one_cycle", load_done, 0);
    check("frame_writes", wr_cnt - w0, data.size());
    check("frame_dones", done_cnt - d0, 1);
  endtask

  initial begin
    logic [7:0] jq[$];
    logic [7:0] dq[$];
    int w0;
    int d0;
    logic [7:0] b;

    for (int a = 0; a < 256; a++) begin
      exp_mem[a] = 8'd0;
      dut_mem[a] = 8'd0;
    end

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("cpu_held_before_load", cpu_rst_n, 0);

    jq = {};
    dq = {};
    dq.push_back(8'h10);
    dq.push_back(8'h20);
    dq.push_back(8'h30);
    send_frame(jq, dq, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
    w0 = wr_cnt;
    d0 = done_cnt;
    send_byte(SYNC, 0);
    send_byte(8'h03, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h30, 0);
    send_byte(8'h03 + 8'h10 + 8'h20 + 8'h30 + 8'h01, 0);
    check("badchk_err", load_err, 1);
    check("badchk_cpu", cpu_rst_n, 0);
    check("badchk_busy", load_busy, 0);
    repeat (2) @(negedge clk);
    check("badchk_writes", wr_cnt - w0, 3);
    check("badchk_no_done", done_cnt - d0, 0);
`endif

    jq = {};
    dq = {};
    jq.push_back(8'h00);
    jq.push_back(8'hFF);
    dq.push_back(8'hA5);
    dq.push_back(8'h07);
    send_frame(jq, dq, 5);

    check("tmo_pre_cpu_run", cpu_rst_n, 1);
    w0 = wr_cnt;
    send_byte(SYNC, 0);
    check("tmo_sync_cpu", cpu_rst_n, 0);
    send_byte(8'h02, 1);
    send_byte(8'h11, 2);
    exp_mem[0] = 8'h11;
    repeat (T - 1) @(negedge clk);
    check("tmo_not_yet_err", load_err, 0);
    check("tmo_not_yet_busy", load_busy, 1);
    @(negedge clk);
    check("tmo_err", load_err, 1);
    check("tmo_busy", load_busy, 0);
    check("tmo_cpu", cpu_rst_n, 0);
    send_byte(8'h02, 0);
    repeat (2) @(negedge clk);
    check("tmo_writes", wr_cnt - w0, 1);
    check("tmo_idle_discard", load_busy, 0);

    jq = {};
    dq = {};
    for (int i = 0; i < 4; i++) dq.push_back(8'($urandom));
    send_frame(jq, dq, 2);

    check("reload_pre_cpu_run", cpu_rst_n, 1);
    jq = {};
    dq = {};
    send_frame(jq, dq, 0);

    d0 = done_cnt;
    send_byte(SYNC, 0);
    send_byte(8'h05, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    exp_mem[0] = 8'h33;
    exp_mem[1] = 8'h44;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    rst = 1'b1;
    @(negedge clk);
    check("midreset_no_done", done_cnt - d0, 0);
    jq = {};
    dq = {};
    for (int i = 0; i < 6; i++) dq.push_back(8'($urandom));
    send_frame(jq, dq, 1);

    for (int f = 0; f < 25; f++) begin
      jq = {};
      dq = {};
      for (int j = 0; j < $urandom_range(3, 0); j++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        jq.push_back(b);
      end
      for (int j = 0; j < $urandom_range(24, 0); j++) dq.push_back(8'($urandom));
      send_frame(jq, dq, 3);
    end

    repeat (2) @(negedge clk);
    for (int a = 0; a < 256; a++) check("mem_image", dut_mem[a], exp_mem[a]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
